// File: rtl/boid_fb_update_scheduler.sv
// Per-frame boid framebuffer updater: erase every previous pixel, then plot every new one.
// Define FB_SCHED_TRAILS_EN to compile out the erase phase so boids leave trails.
module boid_fb_update_scheduler #(
  parameter int NUM_BOIDS = 16,
  parameter int IDX_W     = 4,
  parameter int ADDR_W    = 20,
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              vga_busy,
  output logic [IDX_W-1:0]  boid_idx,
  input  logic [9:0]        boid_x,
  input  logic [8:0]        boid_y,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        overrun_count
);
  localparam int IW = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1;

  typedef enum logic [2:0] {IDLE, ERASE, FETCH, PLOT, DONE} state_t;
  state_t state, state_nx;

  logic [IDX_W-1:0] idx, idx_nx;
  logic             fs_q, fs_edge;
  logic [NUM_BOIDS-1:0][ADDR_W-1:0] prev_addr;
  logic [NUM_BOIDS-1:0]             prev_valid;
  logic [IW-1:0]    sel;
  logic             last, in_range, plot_adv;
  logic [ADDR_W-1:0] addr;

  assign sel      = idx[IW-1:0];
  assign last     = (idx == IDX_W'(NUM_BOIDS - 1));
  assign fs_edge  = frame_start & ~fs_q;
  assign in_range = (32'(boid_x) < 32'(FB_WIDTH)) && (32'(boid_y) < 32'(FB_HEIGHT));
  assign addr     = ADDR_W'(32'(boid_x) + 32'(FB_WIDTH) * 32'(boid_y));
  // Off-screen boids never wait on the VGA reader: nothing to write.
  assign plot_adv = (state == PLOT) && (!in_range || !vga_busy);

  assign boid_idx   = idx;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = 1'b0;
    case (state)
      IDLE: if (fs_edge) begin
        idx_nx = '0;
`ifdef FB_SCHED_TRAILS_EN
        state_nx = FETCH;
`else
        state_nx = ERASE;
`endif
      end
      ERASE: begin
`ifndef FB_SCHED_TRAILS_EN
        if (!prev_valid[sel] || !vga_busy) begin
          if (prev_valid[sel]) begin
            wr_en   = 1'b1;
            wr_addr = prev_addr[sel];
          end
          if (last) begin
            state_nx = FETCH;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
`else
        state_nx = FETCH;
        idx_nx   = '0;
`endif
      end
      FETCH: state_nx = PLOT;
      PLOT: if (plot_adv) begin
        if (in_range) begin
          wr_en   = 1'b1;
          wr_addr = addr;
          wr_data = 1'b1;
        end
        if (last) begin
          state_nx = DONE;
          idx_nx   = '0;
        end else begin
          state_nx = FETCH;
          idx_nx   = idx + 1'b1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      fs_q          <= 1'b0;
      prev_valid    <= '0;
      overrun_count <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      fs_q  <= frame_start;
      if (fs_edge && state != IDLE && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;
      if (plot_adv)
        prev_valid[sel] <= in_range;
    end
  end

  // Address store needs no reset: it is only read where prev_valid is set.
  always_ff @(posedge clk) begin
    if (plot_adv && in_range)
      prev_addr[sel] <= addr;
  end
endmodule

// File: tb/tb_boid_fb_update_scheduler.sv
// Directed bench for boid_fb_update_scheduler with NUM_BOIDS=4 and a 1-cycle-latency position file.
module tb_boid_fb_update_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        vga_busy = 1'b0;
  logic [3:0]  boid_idx;
  logic [9:0]  boid_x = '0;
  logic [8:0]  boid_y = '0;
  logic        wr_en, wr_data, busy, frame_done;
  logic [19:0] wr_addr;
  logic [7:0]  overrun_count;

  int checks = 0;
  int errors = 0;
  int bad = 0;
  int n;
  logic [9:0]  bx[4];
  logic [8:0]  by[4];
  logic [20:0] wq[$];
  logic [20:0] exp_w[8];

  boid_fb_update_scheduler #(.NUM_BOIDS(4), .IDX_W(4), .ADDR_W(20),
    .FB_WIDTH(320), .FB_HEIGHT(480)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .vga_busy(vga_busy),
    .boid_idx(boid_idx), .boid_x(boid_x), .boid_y(boid_y), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .frame_done(frame_done),
    .overrun_count(overrun_count));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    boid_x <= bx[boid_idx[1:0]];
    boid_y <= by[boid_idx[1:0]];
  end

  always @(negedge clk) begin
    if (wr_en) begin
      wq.push_back({wr_data, wr_addr});
      if (vga_busy) bad++;
    end
  end

  function automatic logic [20:0] w(input logic d, input int a);
    return {d, a[19:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int cnt);
    chk({tag, "_count"}, wq.size(), cnt);
    for (int k = 0; k < cnt && k < wq.size(); k++)
      chk({tag, "_write"}, wq[k], exp_w[k]);
  endtask

  // Leaves the bench 1 time unit after the edge that enters the first busy state.
  task automatic pulse_fs();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame_done && cyc < 100);
    if (!frame_done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_pos(input int b, input int x, input int y);
    bx[b] = x[9:0];
    by[b] = y[8:0];
  endtask

  initial begin
    set_pos(0, 0, 0); set_pos(1, 1, 0); set_pos(2, 319, 479); set_pos(3, 5, 2);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_idx", boid_idx, 0);
    chk("rst_overrun", overrun_count, 0);
    reset = 1'b0;

    // Frame 1: nothing to erase, four plots.
    wq.delete();
    pulse_fs();
    wait_done(n);
    chk("f1_done_lat", n, 13);
    exp_w = '{w(1,0), w(1,1), w(1,153599), w(1,645), 0, 0, 0, 0};
    chk_q("f1", 4);
    @(negedge clk);
    chk("f1_done_pulse", frame_done, 0);
    chk("f1_idle", busy, 0);

    // Frame 2: boid 0 moves, all erases precede plots.
    set_pos(0, 2, 0);
    wq.delete();
    pulse_fs();
    wait_done(n);
    chk("f2_done_lat", n, 13);
    exp_w = '{w(0,0), w(0,1), w(0,153599), w(0,645), w(1,2), w(1,1), w(1,153599), w(1,645)};
    chk_q("f2", 8);

    // Frame 3: VGA holds the port for 5 cycles during PLOT(1).
    wq.delete();
    pulse_fs();
    repeat (7) @(posedge clk);
    #1 vga_busy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_wr_en", wr_en, 0);
      chk("stall_idx", boid_idx, 1);
    end
    @(posedge clk); #1 vga_busy = 1'b0;
    @(negedge clk);
    chk("stall_release_en", wr_en, 1);
    chk("stall_release_w", {wr_data, wr_addr}, w(1,1));
    chk("stall_release_idx", boid_idx, 1);
    wait_done(n);
    chk("f3_writes", wq.size(), 8);

    // Frame 4/5: boid 2 off-screen in x, then in y.
    set_pos(2, 320, 0);
    wq.delete();
    pulse_fs();
    wait_done(n);
    exp_w = '{w(0,2), w(0,1), w(0,153599), w(0,645), w(1,2), w(1,1), w(1,645), 0};
    chk_q("f4", 7);
    set_pos(2, 0, 480);
    wq.delete();
    pulse_fs();
    wait_done(n);
    exp_w = '{w(0,2), w(0,1), w(0,645), w(1,2), w(1,1), w(1,645), 0, 0};
    chk_q("f5", 6);

    // Frame 6: three edges while busy are counted and do not restart the update.
    wq.delete();
    pulse_fs();
    repeat (3) pulse_fs();
    wait_done(n);
    chk("ovr_count3", overrun_count, 3);
    chk_q("f6", 6);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || frame_done) n++;
    end
    chk("f6_no_restart", n, 0);

    // Saturation: continuous edges, most of which land while busy.
    repeat (400) pulse_fs();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 50);
    chk("ovr_idle", busy, 0);
    chk("ovr_sat", overrun_count, 255);

    // Reset in PLOT(0); next frame has nothing to erase.
    set_pos(2, 319, 479);
    pulse_fs();
    repeat (5) @(posedge clk);
    #1 chk("pre_rst_plot", {wr_en, wr_data, wr_addr}, {1'b1, w(1,2)});
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_idx", boid_idx, 0);
    chk("mid_rst_overrun", overrun_count, 0);
    chk("mid_rst_addr", wr_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    wq.delete();
    pulse_fs();
    wait_done(n);
    chk("post_rst_lat", n, 13);
    exp_w = '{w(1,2), w(1,1), w(1,153599), w(1,645), 0, 0, 0, 0};
    chk_q("post_rst", 4);

    chk("no_write_while_vga_busy", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
